// File: rtl/vga_sync_gen.sv
// Pixel/line timing generator: column/row counters with registered VGA sync,
// active-region flags, line/frame start pulses and a completed-frame counter.
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [9:0] o_col_count,
  output logic [9:0] o_row_count,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic [7:0] o_frame_count,
  output logic       o_vga_hs_n,
  output logic       o_vga_vs_n
);

  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024 ||
      ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH >= TOTAL_COLS ||
      ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH >= TOTAL_ROWS) begin : g_bad_params
    $error("vga_sync_gen: illegal timing parameter set");
  end

  localparam logic [9:0]  COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [10:0] H_ACT    = 11'(ACTIVE_COLS);
  localparam logic [10:0] V_ACT    = 11'(ACTIVE_ROWS);
  localparam logic [10:0] HS_START = 11'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [10:0] HS_END   = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [10:0] VS_START = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [10:0] VS_END   = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  logic [9:0] r_col;
  logic [9:0] r_row;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_line_start;
  logic       r_frame_start;
  logic [7:0] r_frame_count;
  logic       r_vga_hs_n;
  logic       r_vga_vs_n;

  logic        w_col_wrap;
  logic        w_row_wrap;
  logic [9:0]  w_col_next;
  logic [9:0]  w_row_next;
  logic [10:0] w_col_ext;
  logic [10:0] w_row_ext;

  always_comb begin
    w_col_wrap = (r_col == COL_LAST);
    w_row_wrap = (r_row == ROW_LAST);
    w_col_next = w_col_wrap ? '0 : r_col + 10'd1;
    if (w_col_wrap) begin
      w_row_next = w_row_wrap ? '0 : r_row + 10'd1;
    end else begin
      w_row_next = r_row;
    end
    w_col_ext = {1'b0, w_col_next};
    w_row_ext = {1'b0, w_row_next};
  end

  // Decodes use the next counter values so every output lines up with the counts it accompanies.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col         <= COL_LAST;
      r_row         <= ROW_LAST;
      r_frame_count <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_vga_hs_n    <= 1'b1;
      r_vga_vs_n    <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (i_en) begin
      r_col         <= w_col_next;
      r_row         <= w_row_next;
      r_hsync       <= (w_col_ext < H_ACT);
      r_vsync       <= (w_row_ext < V_ACT);
      r_vga_hs_n    <= !((w_col_ext >= HS_START) && (w_col_ext < HS_END));
      r_vga_vs_n    <= !((w_row_ext >= VS_START) && (w_row_ext < VS_END));
      r_line_start  <= w_col_wrap;
      r_frame_start <= w_col_wrap && w_row_wrap;
      if (w_col_wrap && w_row_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign o_col_count   = r_col;
  assign o_row_count   = r_row;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_count = r_frame_count;
  assign o_vga_hs_n    = r_vga_hs_n;
  assign o_vga_vs_n    = r_vga_vs_n;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance (A) for line-level checks and
// a shrunken-timing instance (B) so whole frames and the 8-bit frame wrap fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;

  logic       a_hs, a_vs, a_ls, a_fs, a_hsn, a_vsn;
  logic [9:0] a_col, a_row;
  logic [7:0] a_fc;
  logic       b_hs, b_vs, b_ls, b_fs, b_hsn, b_vsn;
  logic [9:0] b_col, b_row;
  logic [7:0] b_fc;

  vga_sync_gen u_dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_en(en_a),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_col_count(a_col), .o_row_count(a_row),
    .o_line_start(a_ls), .o_frame_start(a_fs), .o_frame_count(a_fc),
    .o_vga_hs_n(a_hsn), .o_vga_vs_n(a_vsn)
  );

  vga_sync_gen #(
    .TOTAL_COLS(16), .TOTAL_ROWS(8), .ACTIVE_COLS(10), .ACTIVE_ROWS(5),
    .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_en(en_b),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_col_count(b_col), .o_row_count(b_row),
    .o_line_start(b_ls), .o_frame_start(b_fs), .o_frame_count(b_fc),
    .o_vga_hs_n(b_hsn), .o_vga_vs_n(b_vsn)
  );

  int n_cmp = 0;
  int n_mis = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: position is purely a function of enabled edges since reset, starting one
  // step before (0,0); every output follows from that position by the timing rules.
  typedef struct {
    int col; int row; int fc;
    bit hs; bit vs; bit hsn; bit vsn; bit ls; bit fs;
  } exp_t;

  function automatic exp_t model(input longint k, input bit p,
                                 input int tc, input int tr, input int ac, input int ar,
                                 input int hfp, input int hsw, input int vfp, input int vsw);
    exp_t e;
    longint period = longint'(tc) * tr;
    longint lin = period - 1 + k;
    longint pos = lin % period;
    e.col = int'(pos % tc);
    e.row = int'(pos / tc);
    e.fc  = int'((lin / period) % 256);
    e.hs  = e.col < ac;
    e.vs  = e.row < ar;
    e.hsn = !(e.col >= ac + hfp && e.col < ac + hfp + hsw);
    e.vsn = !(e.row >= ar + vfp && e.row < ar + vfp + vsw);
    e.ls  = p && e.col == 0;
    e.fs  = e.ls && e.row == 0;
    return e;
  endfunction

  longint ka = 0, kb = 0;
  bit pa = 1'b0, pb = 1'b0;

  always @(posedge clk) begin
    exp_t ea, eb;
    if (rst_a) begin ka = 0; pa = 1'b0; end
    else if (en_a) begin ka++; pa = 1'b1; end
    else pa = 1'b0;
    if (rst_b) begin kb = 0; pb = 1'b0; end
    else if (en_b) begin kb++; pb = 1'b1; end
    else pb = 1'b0;
    #1;
    if (armed) begin
      ea = model(ka, pa, 800, 525, 640, 480, 16, 96, 10, 2);
      eb = model(kb, pb, 16, 8, 10, 5, 2, 3, 1, 1);
      chk("A.col", 32'(a_col), 32'(ea.col));  chk("A.row", 32'(a_row), 32'(ea.row));
      chk("A.fc", 32'(a_fc), 32'(ea.fc));     chk("A.hsync", 32'(a_hs), 32'(ea.hs));
      chk("A.vsync", 32'(a_vs), 32'(ea.vs));  chk("A.hs_n", 32'(a_hsn), 32'(ea.hsn));
      chk("A.vs_n", 32'(a_vsn), 32'(ea.vsn)); chk("A.line_start", 32'(a_ls), 32'(ea.ls));
      chk("A.frame_start", 32'(a_fs), 32'(ea.fs));
      chk("B.col", 32'(b_col), 32'(eb.col));  chk("B.row", 32'(b_row), 32'(eb.row));
      chk("B.fc", 32'(b_fc), 32'(eb.fc));     chk("B.hsync", 32'(b_hs), 32'(eb.hs));
      chk("B.vsync", 32'(b_vs), 32'(eb.vs));  chk("B.hs_n", 32'(b_hsn), 32'(eb.hsn));
      chk("B.vs_n", 32'(b_vsn), 32'(eb.vsn)); chk("B.line_start", 32'(b_ls), 32'(eb.ls));
      chk("B.frame_start", 32'(b_fs), 32'(eb.fs));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, ".col"}, 32'(a_col), 799);  chk({tag, ".row"}, 32'(a_row), 524);
    chk({tag, ".fc"}, 32'(a_fc), 0);      chk({tag, ".hsync"}, 32'(a_hs), 0);
    chk({tag, ".vsync"}, 32'(a_vs), 0);   chk({tag, ".hs_n"}, 32'(a_hsn), 1);
    chk({tag, ".vs_n"}, 32'(a_vsn), 1);   chk({tag, ".ls"}, 32'(a_ls), 0);
    chk({tag, ".fs"}, 32'(a_fs), 0);
  endtask

  initial begin
    int n_fs, n_vsn, n_vs;
    bit found;
    rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
    cyc(1);
    armed = 1'b1;
    en_a = 1'b1;            // reset must win over enable
    cyc(2);
    chk_a_reset("A.rst");

    rst_a = 1'b0;
    cyc(1);
    chk("A.first.col", 32'(a_col), 0);  chk("A.first.row", 32'(a_row), 0);
    chk("A.first.fs", 32'(a_fs), 1);    chk("A.first.ls", 32'(a_ls), 1);
    chk("A.first.fc", 32'(a_fc), 1);    chk("A.first.hsync", 32'(a_hs), 1);
    chk("A.first.vsync", 32'(a_vs), 1);
    cyc(640);
    chk("A.c640.col", 32'(a_col), 640); chk("A.c640.hsync", 32'(a_hs), 0);
    cyc(16);
    chk("A.c656.hs_n", 32'(a_hsn), 0);
    cyc(95);
    chk("A.c751.col", 32'(a_col), 751); chk("A.c751.hs_n", 32'(a_hsn), 0);
    cyc(1);
    chk("A.c752.hs_n", 32'(a_hsn), 1);
    cyc(48);
    chk("A.line1.col", 32'(a_col), 0);  chk("A.line1.row", 32'(a_row), 1);
    chk("A.line1.ls", 32'(a_ls), 1);    chk("A.line1.fs", 32'(a_fs), 0);
    en_a = 1'b0;
    cyc(5);
    chk("A.hold.ls", 32'(a_ls), 0);     chk("A.hold.col", 32'(a_col), 0);
    en_a = 1'b1;
    cyc(300);
    chk("A.mid.col", 32'(a_col), 300);
    rst_a = 1'b1;
    cyc(1);
    chk_a_reset("A.midrst");

    rst_b = 1'b0; en_b = 1'b0;
    cyc(37);
    chk("B.hold.col", 32'(b_col), 15);  chk("B.hold.row", 32'(b_row), 7);
    chk("B.hold.fs", 32'(b_fs), 0);
    en_b = 1'b1;
    cyc(1);
    chk("B.first.col", 32'(b_col), 0);  chk("B.first.row", 32'(b_row), 0);
    chk("B.first.fs", 32'(b_fs), 1);    chk("B.first.fc", 32'(b_fc), 1);
    n_fs = 0; n_vsn = 0; n_vs = 0;
    for (int i = 0; i < 128; i++) begin
      cyc(1);
      if (b_fs) n_fs++;
      if (!b_vsn) n_vsn++;
      if (!b_vs) n_vs++;
    end
    chk("B.frame.fs_pulses", 32'(n_fs), 1);
    chk("B.frame.vs_n_low", 32'(n_vsn), 16);
    chk("B.frame.vsync_low", 32'(n_vs), 48);
    chk("B.frame.fc", 32'(b_fc), 2);
    cyc(256 * 128);
    chk("B.wrap256.fc", 32'(b_fc), 2);
    for (int i = 0; i < 60; i++) begin
      en_b = (i % 3) != 0;
      cyc(1);
    end
    en_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1);
      found = (b_col == 10'd7) && (b_row == 10'd4);
    end
    chk("B.reach_7_4", 32'(found), 1);
    rst_b = 1'b1;
    cyc(1);
    chk("B.midrst.col", 32'(b_col), 15); chk("B.midrst.row", 32'(b_row), 7);
    chk("B.midrst.fc", 32'(b_fc), 0);    chk("B.midrst.hsync", 32'(b_hs), 0);
    chk("B.midrst.vsync", 32'(b_vs), 0); chk("B.midrst.hs_n", 32'(b_hsn), 1);
    chk("B.midrst.vs_n", 32'(b_vsn), 1); chk("B.midrst.ls", 32'(b_ls), 0);
    chk("B.midrst.fs", 32'(b_fs), 0);
    rst_b = 1'b0; rst_a = 1'b0;
    cyc(20);
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter TOTAL_COLS, default 800: pixels per line, blanking included.
REQ-002 Parameter TOTAL_ROWS, default 525: lines per frame, blanking included.
REQ-003 Parameter ACTIVE_COLS, default 640: visible pixels per line.
REQ-004 Parameter ACTIVE_ROWS, default 480: visible lines per frame.
REQ-005 Parameters H_FRONT_PORCH 16, H_SYNC_WIDTH 96, V_FRONT_PORCH 10, V_SYNC_WIDTH 2: VGA sync pulse placement.
REQ-006 i_clk  input  1  pixel clock (25 MHz); the only clock.
REQ-007 i_rst  input  1  reset, synchronous, active-high.
REQ-008 i_en  input  1  pixel advance enable; counters step only when high.
REQ-009 o_hsync  output  1  high while the column is in the active region.
REQ-010 o_vsync  output  1  high while the row is in the active region.
REQ-011 o_col_count  output  10  current column.
REQ-012 o_row_count  output  10  current row.
REQ-013 o_line_start  output  1  one-cycle pulse when a new line begins (col becomes 0).
REQ-014 o_frame_start  output  1  one-cycle pulse when a new frame begins (col and row become 0).
REQ-015 o_frame_count  output  8  completed-frame counter.
REQ-016 o_vga_hs_n  output  1  monitor hsync, active-low.
REQ-017 o_vga_vs_n  output  1  monitor vsync, active-low.

Function
REQ-018 Column counter: steps +1 on each i_clk edge with i_en=1; wraps TOTAL_COLS-1 -> 0.
REQ-019 Row counter: steps +1 only on the edge where the column wraps; wraps TOTAL_ROWS-1 -> 0.
REQ-020 All outputs are registers updated on the same edge as the counters; zero latency relative to o_col_count/o_row_count.
REQ-021 o_hsync = (col < ACTIVE_COLS) and o_vsync = (row < ACTIVE_ROWS), evaluated for the new counter values.
REQ-022 o_vga_hs_n = 0 iff ACTIVE_COLS+H_FRONT_PORCH <= col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH; otherwise 1.
REQ-023 o_vga_vs_n = 0 iff ACTIVE_ROWS+V_FRONT_PORCH <= row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH; otherwise 1.
REQ-024 o_line_start = 1 for exactly the one cycle following an enabled column wrap; otherwise 0.
REQ-025 o_frame_start = 1 for exactly the one cycle following an enabled column wrap that also wraps the row; o_line_start is also 1 in that cycle.
REQ-026 o_frame_count increments by 1 on every frame wrap; wraps 255 -> 0.
REQ-027 i_en=0: counters, level outputs and o_frame_count hold their values; o_line_start and o_frame_start are forced to 0.
REQ-028 Counter widths are fixed at 10 bits; TOTAL_COLS and TOTAL_ROWS shall be <= 1024.
REQ-029 The parameters satisfy ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH < TOTAL_COLS, and the same relation holds for the row parameters; an illegal set stops elaboration.

Reset
REQ-030 i_rst=1 takes priority over i_en and loads col=TOTAL_COLS-1, row=TOTAL_ROWS-1, o_frame_count=0.
REQ-031 During reset: o_hsync=0, o_vsync=0, o_vga_hs_n=1, o_vga_vs_n=1, o_line_start=0, o_frame_start=0.
REQ-032 On the first enabled edge after reset release, the counters go to (0,0) with o_frame_start=1, o_line_start=1, o_hsync=1, o_vsync=1, and o_frame_count=1.
REQ-033 Reset asserted mid-frame returns the block to the REQ-030 state on the next edge, with no partial pulses.

Verification
REQ-034 Reset, then i_en=1 for 1 cycle -> col=0, row=0, o_frame_start=1, o_frame_count=1, o_hsync=o_vsync=1.
REQ-035 Run from (0,0) for 640 cycles -> col=640, o_hsync=0; at col 656..751 o_vga_hs_n=0; at col 752 it is 1; after 800 cycles total, col=0, row=1, o_line_start=1, o_frame_start=0.
REQ-036 Run 420000 cycles (one full frame) -> o_frame_start pulses once, o_frame_count increments by exactly 1, o_vga_vs_n=0 only on rows 490..491, o_vsync=0 on rows 480..524.
REQ-037 Hold i_en=0 for 37 cycles at col=799, row=524 -> all outputs stable and no pulses; next enabled edge -> (0,0) with o_frame_start=1.
REQ-038 Run 256 frames -> o_frame_count wraps back to its starting value; assert i_rst at col=300, row=200 -> next edge matches REQ-031 exactly.
